// File: rtl/eval_sched_pkg.sv
// Shared types and defaults for the evaluation scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package eval_sched_pkg;

    localparam int N_DEF    = 4;
    localparam int W_DEF    = 4;
    localparam int LAT_DEF  = 1;
    // Tag id is sized for the largest supported requester count (8).
    localparam int TAG_ID_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/eval_sched_rr_arbiter.sv
// Round-robin arbiter: first set req bit at or above ptr (mod N) wins.
// Latency: combinational, 0 cycles.
// Backpressure: none; a grant is offered whenever any req bit is set.
// Ports: req (N requests), ptr (search start index), gnt (one-hot grant).
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [N-1:0] rot;
    logic [N-1:0] rot_oh;
    logic         found;

    // Rotate so that bit 0 corresponds to requester ptr; a plain
    // lowest-bit-first search then implements the round-robin order.
    assign rot = N'({req, req} >> ptr);

    always_comb begin
        rot_oh = '0;
        found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                rot_oh[k] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    // Rotate the one-hot back into requester order.
    assign gnt = N'(({rot_oh, rot_oh} << ptr) >> N);

endmodule

// File: rtl/eval_sched.sv
// Schedules N requesters onto one shared evaluation unit and returns tagged results.
// Latency: grant combinational in cycle T, u_op at T+1, response at T+1+LAT.
// Backpressure: requesters hold req until granted; one grant per cycle, only in RUN with enable.
// Ports: clk/rst, enable, req/op (per requester), gnt, u_op/u_z (unit side),
//        rsp_valid/rsp_id/rsp_z (responses), idle, issue_cnt.
module eval_sched
    import eval_sched_pkg::*;
#(
    parameter  int N   = N_DEF,
    parameter  int W   = W_DEF,
    parameter  int LAT = LAT_DEF,
    localparam int IW  = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] op,
    output logic [N-1:0]   gnt,
    output logic [W-1:0]   u_op,
    input  logic           u_z,
    output logic           rsp_valid,
    output logic [IW-1:0]  rsp_id,
    output logic           rsp_z,
    output logic           idle,
    output logic [7:0]     issue_cnt
);

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] ptr;
    logic [N-1:0]  arb_gnt;
    logic          run_en;
    logic          grant_vld;
    logic [IW-1:0] gnt_idx;
    logic          inflight;
    tag_t          tags [0:LAT];

    rr_arbiter #(.N(N)) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stage LAT is being delivered this cycle, so only earlier stages
    // count as still outstanding when deciding to leave DRAIN.
    always_comb begin
        inflight = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            inflight = inflight | tags[k].valid;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (enable)    state_nxt = ST_RUN;
            ST_RUN:   if (!enable)   state_nxt = ST_DRAIN;
            ST_DRAIN: if (!inflight) state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    // Output logic; reset forces the visible outputs to their idle values
    // in the same cycle, before the registers themselves have cleared.
    always_comb begin
        idle   = rst || (state == ST_IDLE);
        run_en = !rst && enable && (state == ST_RUN);
        gnt    = run_en ? arb_gnt : '0;
    end

    assign grant_vld = |gnt;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) gnt_idx = IW'(i);
        end
    end

    // Operand register, pointer, counter and tag pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            u_op      <= '0;
            issue_cnt <= '0;
            for (int k = 0; k <= LAT; k++) begin
                tags[k] <= '0;
            end
        end else begin
            if (grant_vld) begin
                ptr       <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
                u_op      <= op[gnt_idx*W +: W];
                issue_cnt <= issue_cnt + 8'd1;
            end
            tags[0] <= '{valid: grant_vld, id: TAG_ID_W'(gnt_idx)};
            for (int k = 1; k <= LAT; k++) begin
                tags[k] <= tags[k-1];
            end
        end
    end

    assign rsp_valid = tags[LAT].valid && !rst;
    assign rsp_id    = rst ? '0 : IW'(tags[LAT].id);
    assign rsp_z     = u_z;

endmodule

// File: tb/tb_eval_sched.sv
module tb_eval_sched;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [N-1:0]   req;
    logic [N*W-1:0] op;

    // Instance A: LAT=1, instance B: LAT=3, sharing the same inputs.
    logic [N-1:0] gnt_a, gnt_b;
    logic [W-1:0] u_op_a, u_op_b;
    logic         u_z_a, u_z_b;
    logic         rv_a, rv_b, rz_a, rz_b, idle_a, idle_b;
    logic [1:0]   rid_a, rid_b;
    logic [7:0]   cnt_a, cnt_b;

    int vectors = 0;
    int miscompares = 0;
    int tcyc = 0;

    always #5 clk = ~clk;

    eval_sched #(.N(N), .W(W), .LAT(1)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .req(req), .op(op),
        .gnt(gnt_a), .u_op(u_op_a), .u_z(u_z_a), .rsp_valid(rv_a),
        .rsp_id(rid_a), .rsp_z(rz_a), .idle(idle_a), .issue_cnt(cnt_a)
    );

    eval_sched #(.N(N), .W(W), .LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .enable(enable), .req(req), .op(op),
        .gnt(gnt_b), .u_op(u_op_b), .u_z(u_z_b), .rsp_valid(rv_b),
        .rsp_id(rid_b), .rsp_z(rz_b), .idle(idle_b), .issue_cnt(cnt_b)
    );

    // Behavioural evaluation unit: a fixed boolean of the operand,
    // delivered LAT register stages after u_op is presented.
    function automatic logic fz(input logic [3:0] x);
        return (x[3] & x[2]) | (x[1] ^ x[0]);
    endfunction

    logic [3:0] zp_a = '0;
    logic [3:0] zp_b = '0;
    always @(posedge clk) begin
        zp_a <= {zp_a[2:0], fz(u_op_a)};
        zp_b <= {zp_b[2:0], fz(u_op_b)};
    end
    assign u_z_a = zp_a[0];
    assign u_z_b = zp_b[2];

    // Reference model: per instance, state (0 idle, 1 run, 2 drain),
    // pointer, counter, last operand and a calendar of due responses.
    int         lat_of [2] = '{1, 3};
    int         mst    [2];
    int         mptr   [2];
    int         mcnt   [2];
    logic [3:0] muop   [2];
    bit         sv     [2][64];
    int         sid    [2][64];
    bit         sz     [2][64];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, tcyc, got, exp);
        end
    endtask

    task automatic model_reset(input int m);
        mst[m]  = 0;
        mptr[m] = 0;
        mcnt[m] = 0;
        muop[m] = '0;
        for (int s = 0; s < 64; s++) sv[m][s] = 1'b0;
    endtask

    task automatic check_cycle();
        for (int m = 0; m < 2; m++) begin
            logic [3:0] o_gnt, o_uop, e_gnt;
            logic       o_rv, o_rz, o_idle;
            logic [1:0] o_id;
            logic [7:0] o_cnt;
            string      p;
            int         eg, slot, idx;
            bit         pending;
            o_gnt  = (m == 0) ? gnt_a  : gnt_b;
            o_uop  = (m == 0) ? u_op_a : u_op_b;
            o_rv   = (m == 0) ? rv_a   : rv_b;
            o_rz   = (m == 0) ? rz_a   : rz_b;
            o_idle = (m == 0) ? idle_a : idle_b;
            o_id   = (m == 0) ? rid_a  : rid_b;
            o_cnt  = (m == 0) ? cnt_a  : cnt_b;
            p      = (m == 0) ? "lat1." : "lat3.";
            if (rst) begin
                chk({p, "rst_gnt"}, o_gnt, 0);
                chk({p, "rst_rsp_valid"}, o_rv, 0);
                chk({p, "rst_rsp_id"}, o_id, 0);
                chk({p, "rst_idle"}, o_idle, 1);
                model_reset(m);
            end else begin
                chk({p, "idle"}, o_idle, (mst[m] == 0));
                chk({p, "issue_cnt"}, o_cnt, mcnt[m]);
                chk({p, "u_op"}, o_uop, muop[m]);
                eg = -1;
                if (mst[m] == 1 && enable) begin
                    for (int k = 0; k < N; k++) begin
                        idx = (mptr[m] + k) % N;
                        if (eg < 0 && req[idx]) eg = idx;
                    end
                end
                e_gnt = (eg >= 0) ? 4'(1 << eg) : 4'd0;
                chk({p, "gnt"}, o_gnt, e_gnt);
                slot = tcyc % 64;
                chk({p, "rsp_valid"}, o_rv, sv[m][slot]);
                if (sv[m][slot] && o_rv) begin
                    chk({p, "rsp_id"}, o_id, sid[m][slot]);
                    chk({p, "rsp_z"}, o_rz, sz[m][slot]);
                end
                sv[m][slot] = 1'b0;
                pending = 1'b0;
                for (int s = 0; s < 64; s++) if (sv[m][s]) pending = 1'b1;
                case (mst[m])
                    0: if (enable) mst[m] = 1;
                    1: if (!enable) mst[m] = 2;
                    default: if (!pending) mst[m] = 0;
                endcase
                if (eg >= 0) begin
                    mptr[m] = (eg + 1) % N;
                    mcnt[m] = (mcnt[m] + 1) % 256;
                    muop[m] = op[eg*W +: W];
                    slot = (tcyc + 1 + lat_of[m]) % 64;
                    sv[m][slot]  = 1'b1;
                    sid[m][slot] = eg;
                    sz[m][slot]  = fz(op[eg*W +: W]);
                end
            end
        end
        tcyc++;
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic r, input logic e, input logic [3:0] q, input int n);
        rst    = r;
        enable = e;
        req    = q;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; req = '0; op = 16'h7c3a;
        for (int m = 0; m < 2; m++) model_reset(m);

        // Reset, then a single request from requester 0 with op 1010.
        cyc(1, 0, 4'b0000, 2);
        cyc(0, 1, 4'b0000, 1);
        cyc(0, 1, 4'b0001, 1);
        cyc(0, 1, 4'b0000, 5);

        // All four requesting for 8 cycles from a fresh reset.
        cyc(1, 0, 4'b0000, 1);
        cyc(0, 1, 4'b0000, 1);
        op = 16'h5ac3;
        cyc(0, 1, 4'b1111, 8);
        chk("cnt_after_8", cnt_a, 8);

        // Move the pointer to 2, then check wrap-around search order.
        cyc(0, 1, 4'b0010, 1);
        cyc(0, 1, 4'b0011, 1);
        cyc(0, 1, 4'b0010, 1);

        // Two grants, then drop enable and watch the drain.
        cyc(0, 1, 4'b0011, 2);
        cyc(0, 0, 4'b0011, 6);

        // Reset pulse right after a grant drops the in-flight response.
        cyc(0, 1, 4'b0000, 1);
        cyc(0, 1, 4'b0100, 1);
        cyc(1, 1, 4'b0000, 1);
        cyc(0, 0, 4'b0000, 5);

        // Enable bounces during DRAIN.
        cyc(0, 1, 4'b0000, 1);
        cyc(0, 1, 4'b1001, 3);
        cyc(0, 0, 4'b1001, 1);
        cyc(0, 1, 4'b1001, 8);

        // Randomized traffic with occasional reset and enable drops.
        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 60) == 0);
            enable = ($urandom_range(0, 9) != 0);
            req    = 4'($urandom);
            op     = 16'($urandom);
            step();
        end

        // 256 grants wrap the counter back to zero.
        cyc(1, 0, 4'b0000, 1);
        cyc(0, 1, 4'b0000, 1);
        for (int i = 0; i < 256; i++) begin
            op = 16'($urandom);
            cyc(0, 1, 4'b1111, 1);
        end
        chk("cnt_wrap_lat1", cnt_a, 0);
        chk("cnt_wrap_lat3", cnt_b, 0);
        cyc(0, 0, 4'b0000, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/eval_sched.md
EVAL_SCHED -- requirements
Module: eval_sched

Interface
REQ-001 Parameter N, default 4: number of requesters, 2..8.
REQ-002 Parameter W, default 4: operand width per requester ({a,b,c,d} order, bit W-1 = a).
REQ-003 Parameter LAT, default 1: shared evaluation unit register latency, 1..4.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  scheduler run request.
REQ-007 req  input  N  per-requester request, held until granted.
REQ-008 op  input  N*W  per-requester operand; slice i = op[i*W +: W].
REQ-009 gnt  output  N  one-hot grant, combinational, at most one bit set.
REQ-010 u_op  output  W  registered operand driven to the shared evaluation unit.
REQ-011 u_z  input  1  unit result, valid LAT cycles after u_op is presented.
REQ-012 rsp_valid  output  1  response strobe.
REQ-013 rsp_id  output  clog2(N)  requester index of the response.
REQ-014 rsp_z  output  1  response value, equal to u_z in the rsp_valid cycle.
REQ-015 idle  output  1  high when state is IDLE.
REQ-016 issue_cnt  output  8  count of grants issued since reset.

Function
REQ-017 States IDLE, RUN, DRAIN; IDLE->RUN when enable=1; RUN->DRAIN when enable=0; DRAIN->IDLE when no grant is in flight; otherwise hold state.
REQ-018 Grants are issued only in RUN with enable=1; the FSM and grant use the same-cycle enable value.
REQ-019 Arbitration is round-robin: the search starts at pointer ptr and proceeds upward modulo N; the first set req bit wins.
REQ-020 After a grant to index i, ptr becomes (i+1) mod N; with no grant, ptr holds.
REQ-021 A grant in cycle T loads u_op with op slice i at the end of T; u_op holds its value in cycles without a grant.
REQ-022 Each grant pushes {valid=1, id=i} into a LAT+1-deep tag pipeline; cycles without a grant push valid=0.
REQ-023 rsp_valid=1 and rsp_id=i occur exactly in cycle T+1+LAT for a grant in cycle T, with rsp_z=u_z in that cycle.
REQ-024 Throughput is one grant per cycle; back-to-back grants produce back-to-back responses in grant order.
REQ-025 A requester may drop req without being granted; no grant or response is produced for it.
REQ-026 issue_cnt increments by 1 per grant and wraps from 255 to 0.
REQ-027 If enable re-rises during DRAIN, the drain completes, the FSM passes through IDLE for one cycle, then enters RUN.
REQ-028 In DRAIN, responses for in-flight grants are still delivered.

Reset
REQ-029 While rst=1, state is IDLE, ptr is 0, the tag pipeline is all invalid, u_op is 0, and issue_cnt is 0.
REQ-030 While rst=1, gnt=0 and rsp_valid=0; rsp_id=0 and rsp_z is don't-care.
REQ-031 Reset asserted mid-operation discards all in-flight responses; none appear after rst deasserts.

Structure
REQ-032 A shared package holds the state enum, the tag record type {valid, id}, and the default N/W/LAT constants.
REQ-033 Round-robin selection is one sub-module, rr_arbiter (inputs req and ptr; output one-hot gnt); the FSM, operand register, tag pipeline and counter reside in eval_sched.

Verification
REQ-034 Reset, then enable=1, req=0001, op0=1010 -> gnt=0001 at T; u_op=1010 at T+1; rsp_valid, rsp_id=0, rsp_z=u_z at T+2 (LAT=1).
REQ-035 req=1111 held for 8 cycles -> gnt sequence 0001,0010,0100,1000 repeated; responses have ids 0,1,2,3,0,1,2,3; issue_cnt=8.
REQ-036 ptr=2 with req=0011 -> gnt=0001; the next cycle with req=0010 -> gnt=0010.
REQ-037 Grants at T and T+1, then enable=0 at T+2 -> no grant at T+2; DRAIN; responses at T+2 and T+3; idle=1 from T+4.
REQ-038 rst pulsed one cycle immediately after a grant -> no rsp_valid afterward; issue_cnt=0; ptr=0.
REQ-039 After 256 grants -> issue_cnt=0; LAT=3 build: response appears 4 cycles after its grant.
